// File: rtl/sram_burst_controller.sv
// ============================================================================
// Module   : sram_burst_controller
// Brief    : CPU-word to narrow async-SRAM bridge with bursts and wait states.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_burst_controller #(
    parameter int          CPU_DW      = 32,
    parameter int          SRAM_DW     = 16,
    parameter int          AW          = 18,
    parameter int          BURST_WORDS = 2,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [31:0]                     address,
    input  logic [CPU_DW-1:0]               write_data,
    input  logic [CPU_DW/8-1:0]             byte_en,
    output logic [CPU_DW*BURST_WORDS-1:0]   read_data,
    output logic                            ready,
    inout  wire  [SRAM_DW-1:0]              SRAM_DQ,
    output logic [AW-1:0]                   SRAM_ADDR,
    output logic                            SRAM_WE_N,
    output logic [SRAM_DW/8-1:0]            SRAM_BE_N,
    output logic                            SRAM_CE_N,
    output logic                            SRAM_OE_N
);

    localparam int c_ratio  = CPU_DW / SRAM_DW;
    localparam int c_n_acc  = c_ratio * BURST_WORDS;
    localparam int c_lanes  = SRAM_DW / 8;
    localparam int c_shift  = $clog2(CPU_DW / 8);
    localparam int c_acc_w  = (c_n_acc > 1) ? $clog2(c_n_acc) : 1;
    localparam int c_cyc_w  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [c_cyc_w-1:0]     r_cyc_cnt;
    logic [c_acc_w-1:0]     r_acc_cnt;
    logic [31:0]            r_base;
    logic [CPU_DW-1:0]      r_wdata;
    logic [CPU_DW/8-1:0]    r_be;

    logic [31:0]            w_word_idx;
    logic [31:0]            w_aligned;
    logic [AW-1:0]          w_acc_addr;
    logic                   w_last_cyc;
    logic                   w_dq_oe;
    logic [SRAM_DW-1:0]     w_dq_out;

    // Unsigned subtract: addresses below BASE_ADDR wrap into the top of SRAM.
    assign w_word_idx = (address - BASE_ADDR) >> c_shift;
    assign w_aligned  = w_word_idx & ~32'(BURST_WORDS - 1);
    assign w_acc_addr = AW'(r_base * 32'(c_ratio) + 32'(r_acc_cnt));
    assign w_last_cyc = (r_cyc_cnt == c_cyc_w'(WAIT_CYCLES - 1));

    assign SRAM_CE_N = 1'b0;
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b0;
        SRAM_BE_N = '0;
        SRAM_ADDR = '0;
        w_dq_oe   = 1'b0;
        w_dq_out  = '0;
        case (r_state)
            S_IDLE: begin
                ready = ~(wr_en | rd_en);
                if (wr_en)      w_next = S_WRITE;
                else if (rd_en) w_next = S_READ;
            end
            S_WRITE: begin
                SRAM_ADDR = w_acc_addr;
                SRAM_WE_N = 1'b0;
                SRAM_OE_N = 1'b1;
                SRAM_BE_N = ~r_be[r_acc_cnt*c_lanes +: c_lanes];
                w_dq_oe   = 1'b1;
                w_dq_out  = r_wdata[r_acc_cnt*SRAM_DW +: SRAM_DW];
                if (w_last_cyc && r_acc_cnt == c_acc_w'(c_ratio - 1))
                    w_next = S_DONE;
            end
            S_READ: begin
                SRAM_ADDR = w_acc_addr;
                if (w_last_cyc && r_acc_cnt == c_acc_w'(c_n_acc - 1))
                    w_next = S_DONE;
            end
            S_DONE: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are latched on acceptance so the requester may change them freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt <= '0;
            r_acc_cnt <= '0;
            r_base    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cyc_cnt <= '0;
                    r_acc_cnt <= '0;
                    if (wr_en) begin
                        r_base  <= w_word_idx;
                        r_wdata <= write_data;
                        r_be    <= byte_en;
                    end else if (rd_en) begin
                        r_base  <= w_aligned;
                    end
                end
                S_WRITE, S_READ: begin
                    if (w_last_cyc) begin
                        r_cyc_cnt <= '0;
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (r_state == S_READ)
                            read_data[r_acc_cnt*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
- Parametrised successor to the single-width SRAM controller.
- Bridges the pipeline's memory stage to the external asynchronous SRAM, which has a narrower data bus than the CPU word.
- Adds configurable CPU/SRAM widths, burst length, access wait states, base-address offset, byte-enabled writes, latched requests and registered read data.
- Sits between the MEM stage and a cache/line fill: the CPU stalls on ~ready.

Parameters:
- CPU_DW, 32, CPU data width in bits; must be a multiple of SRAM_DW.
- SRAM_DW, 16, SRAM data bus width in bits; must be a multiple of 8.
- AW, 18, SRAM address width.
- BURST_WORDS, 2, CPU words returned per read burst; power of 2, at least 1.
- WAIT_CYCLES, 1, clock cycles per SRAM access; at least 1.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request; held until ready.
- rd_en  in  1  read request; held until ready.
- address  in  32  CPU byte address.
- write_data  in  CPU_DW  write word.
- byte_en  in  CPU_DW/8  per-byte write enable; bit i covers write_data[8i+7:8i].
- read_data  out  CPU_DW*BURST_WORDS  burst data; word j at bits [CPU_DW*(j+1)-1:CPU_DW*j].
- ready  out  1  request complete, or idle with no request pending.
- SRAM_DQ  inout  SRAM_DW  bidirectional SRAM data bus.
- SRAM_ADDR  out  AW  SRAM word address.
- SRAM_WE_N  out  1  write strobe, active low.
- SRAM_BE_N  out  SRAM_DW/8  byte lane enables, active low.
- SRAM_CE_N  out  1  chip enable; tied 0.
- SRAM_OE_N  out  1  output enable, active low.

Behaviour:
- Derived values:
  - R = CPU_DW/SRAM_DW, the number of accesses per CPU word.
  - N = R*BURST_WORDS.
  - word_idx = (address - BASE_ADDR) >> log2(CPU_DW/8), unsigned 32-bit subtract.
  - SRAM address = (word_idx*R + k), truncated to AW.
- States: IDLE, WRITE, READ, DONE.
- Counters: cyc_cnt counts 0..WAIT_CYCLES-1; acc_cnt is the access index.
- IDLE:
  - ready = ~(wr_en | rd_en).
  - wr_en (priority over rd_en) latches address, write_data and byte_en, clears counters, then goes to WRITE.
  - rd_en latches the base of word_idx aligned down to a multiple of BURST_WORDS, then goes to READ.
  - Input changes after acceptance are ignored.
- WRITE, access k = 0..R-1:
  - SRAM_ADDR = word_idx*R + k.
  - SRAM_DQ = write_data slice k, with k=0 the least significant slice.
  - SRAM_WE_N = 0 and SRAM_OE_N = 1 for all WAIT_CYCLES cycles of the access.
  - SRAM_BE_N = ~byte_en slice k.
  - An access with an all-zero byte_en slice is still issued, with SRAM_BE_N all 1, so latency is fixed.
  - After the last cycle of access R-1, go to DONE.
- READ, access k = 0..N-1:
  - SRAM_ADDR = aligned_base*R + k; SRAM_WE_N = 1, SRAM_OE_N = 0, SRAM_BE_N = 0, SRAM_DQ = Z.
  - On the last cycle of each access, SRAM_DQ is registered into read_data slice k (SRAM_DW-bit slices, k=0 least significant).
  - After access N-1, go to DONE.
- DONE: ready = 1 for exactly one cycle, then IDLE.
  - read_data holds its value until the next read overwrites it.
  - The requester must drop the request in the cycle after ready; a request still asserted in IDLE starts a new transaction.
- Latency, measured from the acceptance edge to the ready cycle:
  - write: R*WAIT_CYCLES + 1 cycles.
  - read: N*WAIT_CYCLES + 1 cycles.
  - At default parameters: write 3, read 5.
- Outside WRITE and READ: SRAM_WE_N = 1, SRAM_OE_N = 0, SRAM_BE_N = 0, SRAM_ADDR = 0, SRAM_DQ = Z.
- SRAM_DQ is driven only while in WRITE.
- Reset, including mid-operation:
  - state goes to IDLE and counters clear.
  - read_data = 0, SRAM_WE_N = 1, SRAM_DQ = Z, SRAM_ADDR = 0.
  - The partial burst is discarded.
- An address below BASE_ADDR wraps modulo 2^AW; no error is flagged.
- Only registers are used; no combinational latches.

Test Plan:
- Defaults: write address=1024, data=0xDEADBEEF, byte_en=4'hF -> cycle 1: ADDR=0, DQ=0xBEEF, WE_N=0; cycle 2: ADDR=1, DQ=0xDEAD, WE_N=0; cycle 3: ready=1, DQ=Z.
- After the above, write 0x11112222 at 1028, then read at 1028 -> ADDR sequence 0,1,2,3; ready on cycle 5; read_data=0x11112222_DEADBEEF.
- Write byte_en=4'b0010, data=0x0000AB00 at 1032, then read 1032 -> SRAM_BE_N=2'b01 on access 0 and 2'b11 on access 1; only byte 1 of word 2 changes to 0xAB.
- WAIT_CYCLES=3 instance, write at 1024 -> ADDR=0 held with WE_N=0 for 3 cycles, then ADDR=1 for 3 cycles; ready on cycle 7.
- wr_en and rd_en both asserted in IDLE -> a write is performed (WE_N pulses); read_data unchanged.
- rst asserted during READ access 2 -> next cycle: IDLE, read_data=0, WE_N=1, DQ=Z; with no request pending, ready=1.
